uart_rx_ctrl: RTL and testbench

Receive-side sequencer for the UART RX path. Detects the start-bit falling edge on the oversampled line and runs the frame through start, data, optional parity and stop phases. It owns the edge/bit counters and issues one-cycle enables to the sampler, start checker, deserializer, parity checker and stop checker. It combines their registered results into a `data_valid` or `framing_err` pulse per frame.

---
 rtl/uart_rx_pkg.sv | 30 +++
 rtl/uart_rx_edge_bit_cnt.sv | 43 ++++
 rtl/uart_rx_ctrl.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the UART receive controller slice.
//   rx_state_t  : frame phase of the receive sequencer
//   samp_point  : edge index at which the sampler output is valid
//   eval_point  : edge index at which a registered checker result is read
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  // Frame phases walked by the receive sequencer.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // The sampler votes around mid-bit, so its output settles two edges
  // after the centre of the bit.
  function automatic int samp_point(input int prescale);
    return prescale / 2 + 2;
  endfunction

  // Checkers register their verdict one edge after they are enabled.
  function automatic int eval_point(input int prescale);
    return prescale / 2 + 3;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// -----------------------------------------------------------------------------
// uart_rx_edge_bit_cnt
// Edge/bit position counter for the UART receive controller.
// Ports:
//   Clk, Rst    : clock, asynchronous active-low reset
//   en          : advance the edge counter this cycle
//   clr         : return both counters to 0 (wins over en)
//   edge_cnt    : oversampling edge within the current bit, 0..PRESCALE-1
//   bit_cnt     : bit index within the frame
//   wrap        : edge_cnt is at its last value and advancing this cycle
// -----------------------------------------------------------------------------
module uart_rx_edge_bit_cnt #(
  parameter int PRESCALE = 8,
  parameter int EW       = $clog2(PRESCALE)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          en,
  input  logic          clr,
  output logic [EW-1:0] edge_cnt,
  output logic [3:0]    bit_cnt,
  output logic          wrap
);

  assign wrap = en && (edge_cnt == EW'(PRESCALE - 1));

  // A wrap closes one bit period and moves on to the next bit index.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (wrap) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else if (en) begin
      edge_cnt <= edge_cnt + EW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side sequencer for the UART RX path. Detects the start edge, walks
// the frame through start/data/parity/stop and pulses the checker enables.
// Ports:
//   Clk, Rst      : clock, asynchronous active-low reset
//   rx_in         : synchronized serial line, idle high
//   par_en        : parity enable, captured when a start edge is detected
//   strt_glitch   : registered start-check verdict (1 = start bit was high)
//   par_err       : registered parity-check verdict
//   stp_err       : registered stop-check verdict
//   dat_samp_en   : sampler enable (same as busy)
//   edge_cnt      : edge index within the current bit
//   bit_cnt       : bit index within the frame (0 = start bit)
//   strt_chk_en, deser_en, par_chk_en, stp_chk_en : one-cycle phase enables
//   data_valid    : one-cycle pulse, frame accepted
//   framing_err   : one-cycle pulse, frame rejected on stop or parity
//   busy          : a frame is in progress
// -----------------------------------------------------------------------------
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE   = 8,
  parameter int DATA_WIDTH = 8,
  parameter int EW         = $clog2(PRESCALE)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          rx_in,
  input  logic          par_en,
  input  logic          strt_glitch,
  input  logic          par_err,
  input  logic          stp_err,
  output logic          dat_samp_en,
  output logic [EW-1:0] edge_cnt,
  output logic [3:0]    bit_cnt,
  output logic          strt_chk_en,
  output logic          deser_en,
  output logic          par_chk_en,
  output logic          stp_chk_en,
  output logic          data_valid,
  output logic          framing_err,
  output logic          busy
);

  localparam int SAMP = samp_point(PRESCALE);
  localparam int EVAL = eval_point(PRESCALE);

  rx_state_t state_q, state_d;

  logic rx_q;
  logic par_en_q, par_en_d;
  logic par_flag_q, par_flag_d;
  logic detect, cnt_en, cnt_clr, wrap;
  logic pre_samp, at_eval;
  logic strt_chk_d, deser_d, par_chk_d, stp_chk_d;
  logic data_valid_d, framing_err_d, busy_d;

  uart_rx_edge_bit_cnt #(
    .PRESCALE (PRESCALE),
    .EW       (EW)
  ) u_cnt (
    .Clk      (Clk),
    .Rst      (Rst),
    .en       (cnt_en),
    .clr      (cnt_clr),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .wrap     (wrap)
  );

  // Only a genuine high-to-low transition starts a frame, so a line stuck
  // low after a bad frame cannot retrigger.
  assign detect   = (state_q == IDLE) && rx_q && !rx_in;
  assign cnt_en   = (state_q != IDLE) || detect;
  assign at_eval  = (edge_cnt == EW'(EVAL));
  // Enables are registered, so they are decided one edge ahead of SAMP.
  assign pre_samp = (edge_cnt == EW'(SAMP - 1));

  assign dat_samp_en = busy;

  // Next-state logic and registered-output inputs. At EVAL the start and
  // stop decisions take priority over the end-of-bit wrap, which lands on
  // the same edge when PRESCALE is 8.
  always_comb begin
    state_d       = state_q;
    par_en_d      = par_en_q;
    par_flag_d    = par_flag_q;
    cnt_clr       = 1'b0;
    data_valid_d  = 1'b0;
    framing_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (detect) begin
          state_d    = START;
          par_en_d   = par_en;
          par_flag_d = 1'b0;
        end
      end
      START: begin
        if (at_eval && strt_glitch) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (wrap && (bit_cnt == 4'(DATA_WIDTH))) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (at_eval) begin
          par_flag_d = par_err;
        end
        if (wrap) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (at_eval) begin
          state_d    = IDLE;
          cnt_clr    = 1'b1;
          par_flag_d = 1'b0;
          if (!stp_err && !par_flag_q) begin
            data_valid_d = 1'b1;
          end else begin
            framing_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
    strt_chk_d = (state_q == START)  && pre_samp;
    deser_d    = (state_q == DATA)   && pre_samp;
    par_chk_d  = (state_q == PARITY) && pre_samp;
    stp_chk_d  = (state_q == STOP)   && pre_samp;
    busy_d     = (state_d != IDLE);
  end

  // State, line history, frame-scoped flags and all registered outputs.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= IDLE;
      rx_q        <= 1'b1;
      par_en_q    <= 1'b0;
      par_flag_q  <= 1'b0;
      strt_chk_en <= 1'b0;
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_q        <= rx_in;
      par_en_q    <= par_en_d;
      par_flag_q  <= par_flag_d;
      strt_chk_en <= strt_chk_d;
      deser_en    <= deser_d;
      par_chk_en  <= par_chk_d;
      stp_chk_en  <= stp_chk_d;
      data_valid  <= data_valid_d;
      framing_err <= framing_err_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed and randomized frames for uart_rx_ctrl. Expected outputs for every
// cycle are computed from the frame timeline (cycle offset from the detect
// cycle) with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

  localparam int P    = 8;
  localparam int DW   = 8;
  localparam int EW   = 3;
  localparam int SAMP = P / 2 + 2;
  localparam int EVAL = P / 2 + 3;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          rx_in = 1'b1;
  logic          par_en = 1'b0;
  logic          strt_glitch = 1'b0;
  logic          par_err = 1'b0;
  logic          stp_err = 1'b0;
  logic          dat_samp_en;
  logic [EW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          strt_chk_en, deser_en, par_chk_en, stp_chk_en;
  logic          data_valid, framing_err, busy;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  always #5 Clk = ~Clk;

  uart_rx_ctrl #(.PRESCALE(P), .DATA_WIDTH(DW), .EW(EW)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .rx_in       (rx_in),
    .par_en      (par_en),
    .strt_glitch (strt_glitch),
    .par_err     (par_err),
    .stp_err     (stp_err),
    .dat_samp_en (dat_samp_en),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .strt_chk_en (strt_chk_en),
    .deser_en    (deser_en),
    .par_chk_en  (par_chk_en),
    .stp_chk_en  (stp_chk_en),
    .data_valid  (data_valid),
    .framing_err (framing_err),
    .busy        (busy)
  );

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input int t,
                             input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s t=%0d observed=%0h expected=%0h", tag, t, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, away from the sampling point.
  task automatic stepCycle();
    @(posedge Clk);
    #1;
  endtask

  // Compare every output against an expected set.
  task automatic checkAll(input string tag, input int t, input logic bE, input int eE,
                          input int cE, input logic sE, input logic dE, input logic pE,
                          input logic tE, input logic vE, input logic fE);
    checkOutput({tag, ".busy"},        t, 32'(busy),        32'(bE));
    checkOutput({tag, ".dat_samp_en"}, t, 32'(dat_samp_en), 32'(bE));
    checkOutput({tag, ".edge_cnt"},    t, 32'(edge_cnt),    32'(eE));
    checkOutput({tag, ".bit_cnt"},     t, 32'(bit_cnt),     32'(cE));
    checkOutput({tag, ".strt_chk_en"}, t, 32'(strt_chk_en), 32'(sE));
    checkOutput({tag, ".deser_en"},    t, 32'(deser_en),    32'(dE));
    checkOutput({tag, ".par_chk_en"},  t, 32'(par_chk_en),  32'(pE));
    checkOutput({tag, ".stp_chk_en"},  t, 32'(stp_chk_en),  32'(tE));
    checkOutput({tag, ".data_valid"},  t, 32'(data_valid),  32'(vE));
    checkOutput({tag, ".framing_err"}, t, 32'(framing_err), 32'(fE));
  endtask

  // Reference timeline: t is the cycle offset from the detect cycle.
  task automatic checkFrame(input int t, input logic glitch, input logic p,
                            input logic pe, input logic se);
    int   tRes, stpBase;
    logic bE, dE;
    tRes    = (DW + 1 + int'(p)) * P + EVAL + 1;
    stpBase = (DW + 1 + int'(p)) * P;
    bE = glitch ? (t >= 1 && t <= EVAL) : (t >= 1 && t < tRes);
    dE = bE && (t >= P + SAMP) && (t <= DW * P + SAMP) && ((t % P) == SAMP);
    checkAll("frame", t, bE, bE ? t % P : 0, bE ? t / P : 0,
             bE && (t == SAMP), dE,
             bE && p && (t == (DW + 1) * P + SAMP),
             bE && (t == stpBase + SAMP),
             !glitch && (t == tRes) && !(p && pe) && !se,
             !glitch && (t == tRes) && ((p && pe) || se));
  endtask

  // Idle cycles with the line held at a fixed level; nothing may start.
  task automatic idleCycles(input int n, input logic level);
    for (int i = 0; i < n; i++) begin
      stepCycle();
      checkAll("idle", i, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rx_in       = level;
      strt_glitch = 1'b0;
      par_err     = 1'b0;
      stp_err     = 1'b0;
    end
  endtask

  // Drive one frame starting with its falling edge in the next cycle. The
  // checker verdicts are driven as a well-behaved checker would return them,
  // one cycle after its enable. par_en is scrambled after the detect cycle.
  task automatic applyStimulus(input logic glitch, input logic p, input logic pe,
                               input logic se, input logic [DW-1:0] data,
                               input logic holdLow, input int abortAt);
    int tRes, tEnd, b;
    tRes = (DW + 1 + int'(p)) * P + EVAL + 1;
    tEnd = glitch ? EVAL + 2 : tRes;
    for (int t = 0; t <= tEnd; t++) begin
      stepCycle();
      checkFrame(t, glitch, p, pe, se);
      if (t == abortAt) begin
        rx_in = 1'b1;
        Rst   = 1'b0;
        #2;
        checkAll("reset", t, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        return;
      end
      b = t / P;
      if (glitch)                  rx_in = (t >= 3);
      else if (t >= tRes)          rx_in = !holdLow;
      else if (b == 0)             rx_in = 1'b0;
      else if (b <= DW)            rx_in = data[b-1];
      else if (p && (b == DW + 1)) rx_in = ^data;
      else                         rx_in = !holdLow;
      par_en      = (t == 0) ? p : 1'($urandom);
      strt_glitch = glitch && (t == EVAL);
      par_err     = p && pe && (t == (DW + 1) * P + EVAL);
      stp_err     = se && (t == tRes - 1);
    end
  endtask

  // Directed scenarios first, then a batch of randomized frames.
  initial begin
    logic g, p, pe, se;
    $display("[TB] reset");
    repeat (3) @(posedge Clk);
    #1;
    checkAll("por", 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    Rst = 1'b1;
    idleCycles(3, 1'b1);

    $display("[TB] clean frame, no parity");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, -1);
    idleCycles(2, 1'b1);

    $display("[TB] start glitch");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, -1);
    idleCycles(2, 1'b1);

    $display("[TB] parity error");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'($urandom), 1'b0, -1);
    idleCycles(2, 1'b1);

    $display("[TB] stop error, line held low");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom), 1'b1, -1);
    idleCycles(12, 1'b0);
    idleCycles(1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom), 1'b0, -1);

    $display("[TB] back-to-back frames");
    idleCycles(1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0, -1);

    $display("[TB] reset mid-frame");
    idleCycles(2, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0, 40);
    stepCycle();
    checkAll("inreset", 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    Rst = 1'b1;
    idleCycles(2, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom), 1'b0, -1);

    $display("[TB] randomized frames");
    for (int n = 0; n < 10; n++) begin
      g  = ($urandom_range(0, 3) == 0);
      p  = 1'($urandom);
      pe = 1'($urandom);
      se = ($urandom_range(0, 2) == 0);
      applyStimulus(g, p, pe, se, 8'($urandom), 1'b0, -1);
      idleCycles(int'($urandom_range(0, 3)), 1'b1);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
